// File: rtl/ppu_spr_eval.sv
// Per-scanline sprite evaluator and sprite pixel generator.
//
// While one line is drawn from the active slot bank, the FSM scans OAM for the
// next line (NEXT_Y), fetches the two pattern planes of each hit and fills a
// shadow slot bank. LINE_START swaps the shadow bank into the active bank and
// restarts the scan.
//
// Ports:
//   PPU_SLOW_CLOCK, RST          clock, synchronous active-high reset
//   LINE_START, NEXT_Y           start evaluation of scanline NEXT_Y
//   SPR_H16, SPR_BASE            8x16 mode, 8x8 pattern table select
//   OAM_ADDR / OAM_DATA          OAM byte read, data combinational
//   CHR_REQ, CHR_ADDR / CHR_DATA pattern read, data valid one cycle after REQ
//   PIX_X, PIX_EN                current draw pixel
//   SPR_PIX, SPR_OPAQUE,
//   SPR_PRIO, SPR_ZERO           winning sprite pixel, registered
//   EVAL_DONE, OVERFLOW          evaluation status levels
module ppu_spr_eval #(
  parameter int unsigned N_SLOTS     = 8,
  parameter int unsigned OAM_ENTRIES = 64,
  parameter logic [7:0]  Y_LIMIT     = 8'hEF
) (
  input  logic        PPU_SLOW_CLOCK,
  input  logic        RST,
  input  logic        LINE_START,
  input  logic [7:0]  NEXT_Y,
  input  logic        SPR_H16,
  input  logic        SPR_BASE,
  output logic [7:0]  OAM_ADDR,
  input  logic [7:0]  OAM_DATA,
  output logic        CHR_REQ,
  output logic [12:0] CHR_ADDR,
  input  logic [7:0]  CHR_DATA,
  input  logic [7:0]  PIX_X,
  input  logic        PIX_EN,
  output logic [3:0]  SPR_PIX,
  output logic        SPR_OPAQUE,
  output logic        SPR_PRIO,
  output logic        SPR_ZERO,
  output logic        EVAL_DONE,
  output logic        OVERFLOW
);

  localparam int unsigned SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned CW = $clog2(N_SLOTS + 1);
  localparam logic [5:0]    LastN = 6'(OAM_ENTRIES - 1);
  localparam logic [CW-1:0] Full  = CW'(N_SLOTS);

  typedef enum logic [2:0] {
    StIdle, StScan, StRdIdx, StRdAttr, StRdX, StChrLsb, StChrMsb, StDone
  } state_e;

  state_e        state_q;
  logic [5:0]    n_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    y_q;
  logic          h16_q, base_q;
  logic [3:0]    d_q;
  logic [7:0]    tile_q, x_q, lsb_q;
  logic          vflip_q;
  logic [3:0]    sattr_q;  // {hflip, prio, pal[1:0]}
  logic          eval_done_q, overflow_q;

  // Slot banks: shadow is filled by evaluation, active feeds the draw logic.
  logic [7:0]         sh_lsb_q [N_SLOTS];
  logic [7:0]         sh_msb_q [N_SLOTS];
  logic [7:0]         sh_x_q   [N_SLOTS];
  logic [3:0]         sh_attr_q[N_SLOTS];
  logic [N_SLOTS-1:0] sh_valid_q, sh_zero_q;
  logic [7:0]         act_lsb_q [N_SLOTS];
  logic [7:0]         act_msb_q [N_SLOTS];
  logic [7:0]         act_x_q   [N_SLOTS];
  logic [3:0]         act_attr_q[N_SLOTS];
  logic [N_SLOTS-1:0] act_valid_q, act_zero_q;

  // Scan hit test; the subtraction wraps so sprites above the line miss.
  logic [7:0] d_scan;
  logic       hit;
  assign d_scan = y_q - OAM_DATA;
  assign hit    = (d_scan < (h16_q ? 8'd16 : 8'd8)) && (OAM_DATA < Y_LIMIT);

  // Pattern address for the sprite being fetched.
  logic [3:0]  row;
  logic        plane;
  logic [12:0] chr_addr_full;
  assign row   = vflip_q ? ((h16_q ? 4'd15 : 4'd7) - d_q) : d_q;
  assign plane = (state_q == StChrLsb);
  assign chr_addr_full = h16_q ? {tile_q[0], tile_q[7:1], row[3], plane, row[2:0]}
                               : {base_q, tile_q, plane, row[2:0]};

  assign CHR_REQ  = (state_q == StRdX) || (state_q == StChrLsb);
  assign CHR_ADDR = CHR_REQ ? chr_addr_full : 13'd0;

  always_comb begin
    OAM_ADDR = 8'h00;
    case (state_q)
      StScan:   OAM_ADDR = {n_q, 2'd0};
      StRdIdx:  OAM_ADDR = {n_q, 2'd1};
      StRdAttr: OAM_ADDR = {n_q, 2'd2};
      StRdX:    OAM_ADDR = {n_q, 2'd3};
      default:  OAM_ADDR = 8'h00;
    endcase
  end

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      state_q     <= StIdle;
      n_q         <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      h16_q       <= 1'b0;
      base_q      <= 1'b0;
      d_q         <= '0;
      tile_q      <= '0;
      x_q         <= '0;
      lsb_q       <= '0;
      vflip_q     <= 1'b0;
      sattr_q     <= '0;
      eval_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      sh_valid_q  <= '0;
      act_valid_q <= '0;
    end else if (LINE_START) begin
      // Any state: commit completed slots only; a slot still in flight (even
      // in StChrMsb) is dropped because it is written on leaving StChrMsb.
      act_lsb_q   <= sh_lsb_q;
      act_msb_q   <= sh_msb_q;
      act_x_q     <= sh_x_q;
      act_attr_q  <= sh_attr_q;
      act_valid_q <= sh_valid_q;
      act_zero_q  <= sh_zero_q;
      sh_valid_q  <= '0;
      eval_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      n_q         <= '0;
      cnt_q       <= '0;
      y_q         <= NEXT_Y;
      h16_q       <= SPR_H16;
      base_q      <= SPR_BASE;
      state_q     <= StScan;
    end else begin
      unique case (state_q)
        StScan: begin
          if (hit) begin
            d_q <= d_scan[3:0];
            if (cnt_q == Full) begin
              overflow_q  <= 1'b1;
              eval_done_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StRdIdx;
            end
          end else if (n_q == LastN) begin
            eval_done_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            n_q <= n_q + 6'd1;
          end
        end
        StRdIdx: begin
          tile_q  <= OAM_DATA;
          state_q <= StRdAttr;
        end
        StRdAttr: begin
          vflip_q <= OAM_DATA[7];
          sattr_q <= {OAM_DATA[6:5], OAM_DATA[1:0]};
          state_q <= StRdX;
        end
        StRdX: begin
          x_q     <= OAM_DATA;
          state_q <= StChrLsb;
        end
        StChrLsb: begin
          lsb_q   <= CHR_DATA;
          state_q <= StChrMsb;
        end
        StChrMsb: begin
          sh_lsb_q[cnt_q[SW-1:0]]   <= lsb_q;
          sh_msb_q[cnt_q[SW-1:0]]   <= CHR_DATA;
          sh_x_q[cnt_q[SW-1:0]]     <= x_q;
          sh_attr_q[cnt_q[SW-1:0]]  <= sattr_q;
          sh_valid_q[cnt_q[SW-1:0]] <= 1'b1;
          sh_zero_q[cnt_q[SW-1:0]]  <= (n_q == 6'd0);
          cnt_q <= cnt_q + CW'(1);
          if (n_q == LastN) begin
            eval_done_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            n_q     <= n_q + 6'd1;
            state_q <= StScan;
          end
        end
        default: ;  // StIdle and StDone wait for LINE_START
      endcase
    end
  end

  // Draw: per-slot coverage and colour. The 9-bit offset makes pixels left of
  // the sprite wrap to >= 256, so sprites near X=255 clip instead of wrapping.
  logic [8:0]         slot_off [N_SLOTS];
  logic [2:0]         slot_bit [N_SLOTS];
  logic [1:0]         slot_col [N_SLOTS];
  logic [N_SLOTS-1:0] slot_hit;

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      slot_off[i] = {1'b0, PIX_X} - {1'b0, act_x_q[i]};
      slot_bit[i] = act_attr_q[i][3] ? slot_off[i][2:0] : 3'd7 - slot_off[i][2:0];
      slot_col[i] = {act_msb_q[i][slot_bit[i]], act_lsb_q[i][slot_bit[i]]};
      slot_hit[i] = act_valid_q[i] && (slot_off[i] < 9'd8) && (slot_col[i] != 2'b00);
    end
  end

  logic       win;
  logic [3:0] win_pix;
  logic       win_prio, win_zero;

  // Descending scan so the lowest-index opaque slot is the last assignment.
  always_comb begin
    win      = 1'b0;
    win_pix  = '0;
    win_prio = 1'b0;
    win_zero = 1'b0;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        win      = 1'b1;
        win_pix  = {act_attr_q[i][1:0], slot_col[i]};
        win_prio = act_attr_q[i][2];
        win_zero = act_zero_q[i];
      end
    end
  end

  logic [3:0] pix_q;
  logic       opaque_q, prio_q, zero_q;

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      pix_q    <= '0;
      opaque_q <= 1'b0;
      prio_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      pix_q    <= (PIX_EN && win) ? win_pix : 4'd0;
      opaque_q <= PIX_EN && win;
      prio_q   <= PIX_EN && win && win_prio;
      zero_q   <= PIX_EN && win && win_zero;
    end
  end

  assign SPR_PIX    = pix_q;
  assign SPR_OPAQUE = opaque_q;
  assign SPR_PRIO   = prio_q;
  assign SPR_ZERO   = zero_q;
  assign EVAL_DONE  = eval_done_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_ppu_spr_eval.sv
// Directed bench for ppu_spr_eval with an OAM array and a one-cycle CHR model.
module tb_ppu_spr_eval;

  logic        clk = 1'b0;
  logic        rst, line_start, spr_h16, spr_base, chr_req, pix_en;
  logic [7:0]  next_y, oam_addr, oam_data, chr_data, pix_x;
  logic [12:0] chr_addr;
  logic [3:0]  spr_pix;
  logic        spr_opaque, spr_prio, spr_zero, eval_done, overflow;

  always #5 clk = ~clk;

  ppu_spr_eval #(
    .N_SLOTS    (8),
    .OAM_ENTRIES(64),
    .Y_LIMIT    (8'hEF)
  ) dut (
    .PPU_SLOW_CLOCK(clk),
    .RST           (rst),
    .LINE_START    (line_start),
    .NEXT_Y        (next_y),
    .SPR_H16       (spr_h16),
    .SPR_BASE      (spr_base),
    .OAM_ADDR      (oam_addr),
    .OAM_DATA      (oam_data),
    .CHR_REQ       (chr_req),
    .CHR_ADDR      (chr_addr),
    .CHR_DATA      (chr_data),
    .PIX_X         (pix_x),
    .PIX_EN        (pix_en),
    .SPR_PIX       (spr_pix),
    .SPR_OPAQUE    (spr_opaque),
    .SPR_PRIO      (spr_prio),
    .SPR_ZERO      (spr_zero),
    .EVAL_DONE     (eval_done),
    .OVERFLOW      (overflow)
  );

  logic [7:0]  oam     [256];
  logic [7:0]  chr_mem [8192];
  logic [12:0] chr_log [$];

  assign oam_data = oam[oam_addr];

  always @(posedge clk) begin
    if (chr_req) begin
      chr_data <= chr_mem[chr_addr];
      chr_log.push_back(chr_addr);
    end else begin
      chr_data <= 8'h00;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
  endtask

  task automatic set_spr(input int idx, input logic [7:0] y, input logic [7:0] t,
                         input logic [7:0] a, input logic [7:0] x);
    oam[idx*4]     = y;
    oam[idx*4 + 1] = t;
    oam[idx*4 + 2] = a;
    oam[idx*4 + 3] = x;
  endtask

  task automatic start_line(input logic [7:0] y, input logic h16, input logic base);
    line_start = 1'b1;
    next_y     = y;
    spr_h16    = h16;
    spr_base   = base;
    step();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!eval_done && k < budget) begin
      step();
      k++;
    end
    check_eq("eval_done_timeout", 32'(eval_done), 32'd1);
  endtask

  // Output appears one clock after PIX_X is presented.
  task automatic pix_check(input string tag, input logic [7:0] x, input logic [3:0] pix,
                           input logic prio, input logic zero);
    pix_x  = x;
    pix_en = 1'b1;
    step();
    check_eq(tag, 32'({spr_opaque, spr_prio, spr_zero, spr_pix}),
             32'({|pix[1:0], prio, zero, pix}));
  endtask

  // lsb=B4, msb=6C, no hflip: bit 7-o gives colours 1,2,3,1,2,3,0,0.
  logic [3:0] t1_exp [8] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};

  initial begin
    rst = 1'b1; line_start = 1'b0; next_y = 8'd0; spr_h16 = 1'b0; spr_base = 1'b0;
    pix_x = 8'd0; pix_en = 1'b0;
    for (int i = 0; i < 8192; i++) chr_mem[i] = 8'h00;
    clear_oam();
    step();
    step();
    check_eq("rst_oam_chr", 32'({oam_addr, chr_req, chr_addr}), 32'd0);
    check_eq("rst_spr_status",
             32'({spr_pix, spr_opaque, spr_prio, spr_zero, eval_done, overflow}), 32'd0);
    rst = 1'b0;
    step();
    step();
    check_eq("idle_hold", 32'({eval_done, oam_addr, chr_req}), 32'd0);

    // Single 8x8 sprite, timing and CHR addresses.
    set_spr(0, 8'd10, 8'd5, 8'h00, 8'd20);
    chr_mem[13'h052] = 8'hB4;
    chr_mem[13'h05A] = 8'h6C;
    chr_log.delete();
    start_line(8'd12, 1'b0, 1'b0);
    check_eq("t1_scan_addr", 32'(oam_addr), 32'h00);
    for (int c = 1; c <= 69; c++) begin
      step();
      if (c == 1) check_eq("t1_idx_addr", 32'(oam_addr), 32'h01);
      if (c == 3) check_eq("t1_req_lsb", 32'({chr_req, chr_addr}), 32'({1'b1, 13'h052}));
      if (c == 4) check_eq("t1_req_msb", 32'({chr_req, chr_addr}), 32'({1'b1, 13'h05A}));
      if (c == 5) check_eq("t1_req_low", 32'(chr_req), 32'd0);
      if (c == 68) check_eq("t1_not_done_68", 32'(eval_done), 32'd0);
    end
    check_eq("t1_done_69", 32'({eval_done, overflow}), 32'b10);
    check_eq("t1_chr_count", 32'(chr_log.size()), 32'd2);
    if (chr_log.size() >= 2) begin
      check_eq("t1_log0", 32'(chr_log[0]), 32'h052);
      check_eq("t1_log1", 32'(chr_log[1]), 32'h05A);
    end
    start_line(8'd200, 1'b0, 1'b0);
    pix_check("t1_x19", 8'd19, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      pix_check($sformatf("t1_x%0d", 20 + i), 8'(20 + i), t1_exp[i], 1'b0, t1_exp[i] != 4'd0);
    pix_check("t1_x28", 8'd28, 4'd0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);

    // Ten sprites on one line: eight slots, then overflow.
    clear_oam();
    for (int i = 0; i < 10; i++) begin
      set_spr(i, 8'd30, 8'(i), 8'h00, 8'(i * 10));
      chr_mem[i * 16] = 8'hFF;
    end
    chr_log.delete();
    start_line(8'd30, 1'b0, 1'b0);
    wait_done(200);
    check_eq("t2_overflow", 32'(overflow), 32'd1);
    check_eq("t2_chr_count", 32'(chr_log.size()), 32'd16);
    start_line(8'd200, 1'b0, 1'b0);
    check_eq("t2_overflow_cleared", 32'({overflow, eval_done}), 32'd0);
    pix_check("t2_x0", 8'd0, 4'd1, 1'b0, 1'b1);
    pix_check("t2_x70", 8'd70, 4'd1, 1'b0, 1'b0);
    pix_check("t2_x77", 8'd77, 4'd1, 1'b0, 1'b0);
    pix_check("t2_x78", 8'd78, 4'd0, 1'b0, 1'b0);
    pix_check("t2_x80_ninth", 8'd80, 4'd0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);

    // 8x16 with vflip+hflip: d=2, row=15-2=13, tile=0x83,
    // addr {tile[0], tile[7:1], row[3], plane, row[2:0]} -> 0x1835 / 0x183D.
    clear_oam();
    set_spr(3, 8'd0, 8'h83, 8'hC2, 8'd100);
    chr_mem[13'h1835] = 8'h0F;
    chr_mem[13'h183D] = 8'h00;
    chr_log.delete();
    start_line(8'd2, 1'b1, 1'b0);
    wait_done(200);
    check_eq("t3_chr_count", 32'(chr_log.size()), 32'd2);
    if (chr_log.size() >= 2) begin
      check_eq("t3_log_lsb", 32'(chr_log[0]), 32'h1835);
      check_eq("t3_log_msb", 32'(chr_log[1]), 32'h183D);
    end
    start_line(8'd200, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      pix_check($sformatf("t3_x%0d", 100 + i), 8'(100 + i), (i < 4) ? 4'h9 : 4'h0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);

    // Overlap: slot 0 at X=50 (prio, transparent left half), slot 1 at X=48.
    clear_oam();
    set_spr(0, 8'd50, 8'd1, 8'h20, 8'd50);
    set_spr(1, 8'd50, 8'd2, 8'h01, 8'd48);
    chr_mem[13'h010] = 8'h0F;
    chr_mem[13'h018] = 8'h00;
    chr_mem[13'h020] = 8'hFF;
    chr_mem[13'h028] = 8'hFF;
    start_line(8'd50, 1'b0, 1'b0);
    wait_done(200);
    start_line(8'd200, 1'b0, 1'b0);
    pix_check("t4_x48", 8'd48, 4'h7, 1'b0, 1'b0);
    pix_check("t4_x50_under", 8'd50, 4'h7, 1'b0, 1'b0);
    pix_check("t4_x54_front", 8'd54, 4'h1, 1'b1, 1'b1);
    pix_check("t4_x55_front", 8'd55, 4'h1, 1'b1, 1'b1);
    pix_check("t4_x56", 8'd56, 4'h1, 1'b1, 1'b1);
    pix_check("t4_x58", 8'd58, 4'h0, 1'b0, 1'b0);
    pix_x = 8'd54;
    pix_en = 1'b0;
    step();
    check_eq("t4_pix_en_off", 32'({spr_opaque, spr_prio, spr_zero, spr_pix}), 32'd0);
    wait_done(200);

    // Right-edge clip.
    clear_oam();
    set_spr(0, 8'd60, 8'd3, 8'h00, 8'd252);
    chr_mem[13'h030] = 8'hFF;
    start_line(8'd60, 1'b0, 1'b0);
    wait_done(200);
    start_line(8'd200, 1'b0, 1'b0);
    pix_check("t5_x251", 8'd251, 4'd0, 1'b0, 1'b0);
    for (int i = 252; i < 256; i++)
      pix_check($sformatf("t5_x%0d", i), 8'(i), 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      pix_check($sformatf("t5_wrap_x%0d", i), 8'(i), 4'd0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);

    // Abort mid-scan: slot 0 committed, entry 40 never reached.
    clear_oam();
    set_spr(0, 8'd70, 8'd4, 8'h00, 8'd10);
    set_spr(40, 8'd70, 8'd5, 8'h00, 8'd30);
    chr_mem[13'h040] = 8'hFF;
    chr_mem[13'h050] = 8'hFF;
    start_line(8'd70, 1'b0, 1'b0);
    repeat (10) step();
    start_line(8'd200, 1'b0, 1'b0);
    check_eq("t5_abort_restart", 32'(eval_done), 32'd0);
    pix_check("t5_partial_x10", 8'd10, 4'd1, 1'b0, 1'b1);
    pix_check("t5_partial_x30", 8'd30, 4'd0, 1'b0, 1'b0);
    pix_check("t5_partial_x252", 8'd252, 4'd0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);
    start_line(8'd200, 1'b0, 1'b0);
    pix_check("t5_no_stale", 8'd10, 4'd0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);
    // Abort while the pattern fetch is in flight: the slot is dropped.
    start_line(8'd70, 1'b0, 1'b0);
    repeat (4) step();
    start_line(8'd200, 1'b0, 1'b0);
    pix_check("t5_half_drop", 8'd10, 4'd0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);

    // Reset in the middle of a pattern fetch.
    clear_oam();
    set_spr(0, 8'd80, 8'd6, 8'h00, 8'd40);
    chr_mem[13'h060] = 8'hFF;
    start_line(8'd80, 1'b0, 1'b0);
    wait_done(200);
    start_line(8'd80, 1'b0, 1'b0);
    pix_check("t6_before_rst", 8'd40, 4'd1, 1'b0, 1'b1);
    repeat (3) step();
    check_eq("t6_in_chr_lsb", 32'({chr_req, chr_addr}), 32'({1'b1, 13'h068}));
    rst = 1'b1;
    step();
    check_eq("t6_rst_oam_chr", 32'({oam_addr, chr_req, chr_addr}), 32'd0);
    check_eq("t6_rst_spr_status",
             32'({spr_pix, spr_opaque, spr_prio, spr_zero, eval_done, overflow}), 32'd0);
    rst = 1'b0;
    step();
    step();
    check_eq("t6_idle_after_rst", 32'({eval_done, oam_addr, chr_req, spr_opaque}), 32'd0);
    start_line(8'd200, 1'b0, 1'b0);
    pix_check("t6_first_line", 8'd40, 4'd0, 1'b0, 1'b0);
    pix_en = 1'b0;
    wait_done(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
